dmem_sram_bridge: RTL



---
 rtl/dmem_sram_bridge_pkg.sv | 31 +++
 rtl/dmem_sram_bridge_addr_map.sv | 36 +++
 rtl/dmem_sram_bridge.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/dmem_sram_bridge_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_sram_bridge_pkg
//  Description : Shared definitions for the MEM-stage SRAM-like bus bridge:
//                FSM state encoding, bus size codes and KSEG mapping constants.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package dmem_sram_bridge_pkg;

  // Bridge FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,   // waiting for a MEM-stage access
    ST_ADDR = 2'd1,   // request held on the bus until accepted
    ST_DATA = 2'd2,   // address accepted, waiting for the data phase
    ST_DONE = 2'd3    // transfer finished, result held for the pipeline
  } bridge_state_t;

  // Bus / CPU access size codes
  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  // Unmapped cached/uncached kernel segments (kseg0/kseg1) have top bits 2'b10;
  // the physical address is obtained by clearing the top three bits.
  localparam logic [1:0]  KSEG_TAG     = 2'b10;
  localparam int          KSEG_CLR_W   = 3;
  localparam logic [31:0] KSEG_MASK    = 32'hE000_0000;

endpackage : dmem_sram_bridge_pkg
`default_nettype wire

// File: rtl/dmem_sram_bridge_addr_map.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_sram_bridge_addr_map
//  Description : Combinational virtual-to-physical address translation for
//                the fixed-mapped kernel segments. Addresses in
//                0x8000_0000..0xBFFF_FFFF have their top three bits cleared;
//                everything else passes through unchanged.
//  Ports       : i_vaddr  - virtual address
//                o_paddr  - physical address
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_sram_bridge_addr_map
  import dmem_sram_bridge_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int MAP_KSEG = 1
) (
  input  logic [ADDR_W-1:0] i_vaddr,
  output logic [ADDR_W-1:0] o_paddr
);

  generate
    if (MAP_KSEG != 0) begin : g_kseg
      always_comb begin
        o_paddr = i_vaddr;
        if (i_vaddr[ADDR_W-1 -: 2] == KSEG_TAG) begin
          o_paddr[ADDR_W-1 -: KSEG_CLR_W] = '0;
        end
      end
    end else begin : g_pass
      assign o_paddr = i_vaddr;
    end
  endgenerate

endmodule : dmem_sram_bridge_addr_map
`default_nettype wire

// File: rtl/dmem_sram_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_sram_bridge
//  Description : Converts single-cycle MEM-stage data accesses into one
//                transaction each on a split address/data handshake bus.
//                Stalls the pipeline until the data phase completes and holds
//                the load result while the pipeline is stalled elsewhere.
//  Ports       : clk, rst (sync, active-low)
//                cpu_*        - MEM-stage request, cancel and load data
//                pipe_stall   - MEM-stage stall from the hazard unit
//                stallreq_o   - stall request to the hazard unit
//                data_*       - SRAM-like bus (req/addr_ok/data_ok handshake)
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_sram_bridge
  import dmem_sram_bridge_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAP_KSEG = 1
) (
  input  logic              clk,
  input  logic              rst,
  // MEM-stage side
  input  logic              cpu_en,
  input  logic              cpu_we,
  input  logic [3:0]        cpu_sel,
  input  logic [1:0]        cpu_size,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_cancel,
  input  logic              pipe_stall,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              stallreq_o,
  // Bus side
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [ADDR_W-1:0] data_addr,
  output logic [DATA_W-1:0] data_wdata,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [DATA_W-1:0] data_rdata
);

  bridge_state_t     r_state;
  logic              r_data_req;
  logic              r_wr;
  logic [1:0]        r_size;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic              r_discard;

  logic [ADDR_W-1:0] w_paddr;
  logic              w_issue;
  logic              w_complete;
  logic              w_drop;
  logic              w_unused;

  // Byte lanes are implied by size and addr[1:0]; the lane mask is not sent.
  assign w_unused = ^cpu_sel;

  dmem_sram_bridge_addr_map #(
    .ADDR_W   (ADDR_W),
    .MAP_KSEG (MAP_KSEG)
  ) u_addr_map (
    .i_vaddr (cpu_addr),
    .o_paddr (w_paddr)
  );

  assign w_issue = cpu_en & ~cpu_cancel;

  // Data phase ends either in DATA, or in ADDR when the slave accepts the
  // address and finishes the data phase in the same cycle.
  assign w_complete = ((r_state == ST_ADDR) & data_addr_ok & data_data_ok) |
                      ((r_state == ST_DATA) & data_data_ok);

  // A cancel arriving in the completion cycle itself also kills the result.
  assign w_drop = r_discard | cpu_cancel;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_data_req <= 1'b0;
      r_wr       <= 1'b0;
      r_size     <= SIZE_B;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_discard  <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          r_discard <= 1'b0;
          if (w_issue) begin
            r_wr       <= cpu_we;
            r_size     <= cpu_size;
            r_addr     <= w_paddr;
            r_wdata    <= cpu_wdata;
            r_data_req <= 1'b1;
            r_state    <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          // The request stays up until accepted, even after a cancel.
          if (cpu_cancel) r_discard <= 1'b1;
          if (data_addr_ok) begin
            r_data_req <= 1'b0;
            r_state    <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (cpu_cancel) r_discard <= 1'b1;
        end
        ST_DONE: begin
          // Retire, or drop on cancel; a lingering cpu_en is never re-issued.
          if (cpu_cancel || !pipe_stall) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase

      // Completion overrides the ADDR->DATA step above.
      if (w_complete) begin
        if (w_drop) begin
          r_state   <= ST_IDLE;
          r_discard <= 1'b0;
        end else begin
          r_state <= ST_DONE;
          if (!r_wr) r_rdata <= data_rdata;
        end
      end
    end
  end

  assign stallreq_o = (r_state == ST_ADDR) | (r_state == ST_DATA) |
                      ((r_state == ST_IDLE) & w_issue);

  assign cpu_rdata  = r_rdata;
  assign data_req   = r_data_req;
  assign data_wr    = r_wr;
  assign data_size  = r_size;
  assign data_addr  = r_addr;
  assign data_wdata = r_wdata;

endmodule : dmem_sram_bridge
`default_nettype wire
